// File: rtl/mp_compact_fifo.sv
// -----------------------------------------------------------------------------
// mp_compact_fifo
//   Multi-port in-order FIFO for L1D request/refill buffering. Up to ENQ_WIDTH
//   entries are accepted and up to DEQ_WIDTH entries are delivered per cycle.
//   Sparse enqueue valids are compacted into consecutive slots. Dequeue pops
//   only the contiguous ready prefix starting at lane 0.
//
// Ports
//   clk                clock
//   rst                synchronous, active-high reset
//   flush_i            discard all contents (wins over enqueue and dequeue)
//   enqueue_vld_i      per-lane enqueue valid, may be sparse
//   enqueue_payload_i  lane i at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
//   enqueue_rdy_o      per-lane enqueue ready
//   dequeue_vld_o      lane i holds the i-th oldest entry
//   dequeue_payload_o  lane i = mem[(head+i) mod DEPTH]
//   dequeue_rdy_i      per-lane consumer ready
//   count_o            current occupancy
//   empty_o / full_o   count==0 / count==DEPTH
//   almost_full_o      count >= AFULL_THRESH
//   peak_cnt_o         highest occupancy since reset (MP_FIFO_STATS_EN only)
//
// Configuration macro
//   MP_FIFO_STATS_EN   adds the peak_cnt_o port and its register
// -----------------------------------------------------------------------------
module mp_compact_fifo #(
    parameter int PAYLOAD_WIDTH  = 64,
    parameter int ENQ_WIDTH      = 4,
    parameter int DEQ_WIDTH      = 4,
    parameter int DEPTH          = 16,
    parameter int MUST_TAKEN_ALL = 1,
    parameter int AFULL_THRESH   = 12,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic [ENQ_WIDTH-1:0]               enqueue_vld_i,
    input  logic [ENQ_WIDTH*PAYLOAD_WIDTH-1:0] enqueue_payload_i,
    output logic [ENQ_WIDTH-1:0]               enqueue_rdy_o,
    output logic [DEQ_WIDTH-1:0]               dequeue_vld_o,
    output logic [DEQ_WIDTH*PAYLOAD_WIDTH-1:0] dequeue_payload_o,
    input  logic [DEQ_WIDTH-1:0]               dequeue_rdy_i,
    output logic [CNT_W-1:0]                   count_o,
    output logic                               empty_o,
    output logic                               full_o,
    output logic                               almost_full_o
`ifdef MP_FIFO_STATS_EN
    ,
    output logic [CNT_W-1:0]                   peak_cnt_o
`endif
);

    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned ENQ_U   = ENQ_WIDTH;
    localparam int unsigned AFULL_U = AFULL_THRESH;

    // Registered state
    logic [PTR_W-1:0]         head_q;
    logic [PTR_W-1:0]         tail_q;
    logic [CNT_W-1:0]         count_q;
    logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];

    // Combinational per-cycle decisions
    int unsigned              count_int;
    int unsigned              free_int;
    int unsigned              seen;
    int unsigned              enq_num;
    int unsigned              deq_num;
    logic                     deq_gap;
    logic [ENQ_WIDTH-1:0]     enq_rdy;
    logic [ENQ_WIDTH-1:0]     enq_fire;
    logic [PTR_W-1:0]         enq_slot [ENQ_WIDTH];
    logic [DEQ_WIDTH-1:0]     deq_vld;
    logic [DEQ_WIDTH-1:0]     deq_fire;
    logic [CNT_W-1:0]         count_nxt;

    // Pointer offset modulo DEPTH. Offsets never exceed DEPTH, so one
    // compare-subtract is enough and DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(ptr) + off;
        if (sum >= DEPTH_U) begin
            sum = sum - DEPTH_U;
        end
        return PTR_W'(sum);
    endfunction

    // NOTE: combinational logic uses blocking assignments and gives every
    // variable a default first, so running sums work and no latch is inferred.
    always_comb begin
        count_int = 32'(count_q);
        free_int  = DEPTH_U - count_int;

        // Enqueue ready; free space comes from registered state only, so a
        // same-cycle dequeue never makes room for an enqueue.
        enq_rdy = '0;
        seen    = 0;
        if (!flush_i) begin
            if (MUST_TAKEN_ALL != 0) begin
                enq_rdy = {ENQ_WIDTH{free_int >= ENQ_U}};
            end else begin
                // Lane i is ready if all valid lanes up to and including it fit.
                for (int i = 0; i < ENQ_WIDTH; i++) begin
                    if (enqueue_vld_i[i]) begin
                        seen = seen + 1;
                    end
                    enq_rdy[i] = (seen <= free_int);
                end
            end
        end
        enq_fire = enqueue_vld_i & enq_rdy;

        // Compaction: each firing lane lands after the lanes below it that fired.
        enq_num = 0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            enq_slot[i] = wrap_add(tail_q, enq_num);
            if (enq_fire[i]) begin
                enq_num = enq_num + 1;
            end
        end

        // Dequeue: lane i presents the i-th oldest entry.
        deq_vld           = '0;
        dequeue_payload_o = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_vld[i] = !flush_i && (count_int > 32'(i));
            dequeue_payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[wrap_add(head_q, 32'(i))];
        end
        deq_fire = deq_vld & dequeue_rdy_i;

        // Only the contiguous fired prefix pops; lanes above a gap are
        // re-presented next cycle.
        deq_num = 0;
        deq_gap = 1'b0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            if (deq_fire[i] && !deq_gap) begin
                deq_num = deq_num + 1;
            end else begin
                deq_gap = 1'b1;
            end
        end

        count_nxt = CNT_W'(count_int + enq_num - deq_num);
    end

    // NOTE: reset is synchronous (sampled at the clock edge) and shares the
    // flush path, so a mid-operation reset empties the FIFO exactly like flush.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= wrap_add(head_q, deq_num);
            tail_q  <= wrap_add(tail_q, enq_num);
            count_q <= count_nxt;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // was written, because dequeue_vld_o is derived from count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_fire[i] && !rst) begin
                mem[enq_slot[i]] <= enqueue_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    assign enqueue_rdy_o = enq_rdy;
    assign dequeue_vld_o = deq_vld;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_int == DEPTH_U);
    assign almost_full_o = (count_int >= AFULL_U);

`ifdef MP_FIFO_STATS_EN
    // High-water mark; flush leaves it alone, only rst clears it.
    logic [CNT_W-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (!flush_i && (count_nxt > peak_q)) begin
            peak_q <= count_nxt;
        end
    end

    assign peak_cnt_o = peak_q;
`endif

endmodule
